dmem_ctrl: RTL and testbench

Data-memory controller that sits between the execute stage's load/store port and the tagged, split-transaction main-memory bus. It accepts one load or store command at a time and holds execute with `dmem_busy` while the command is in flight. For loads it issues a doubleword read, waits for the matching response tag, then extracts, aligns and sign- or zero-extends the addressed byte, half or word. It returns that value on `Dmem2load_data` with a one-cycle `load_done` pulse.

---
 rtl/dmem_ctrl_if.sv | 40 ++++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Bundle of the execute-side load/store port and the tagged split-transaction
// memory bus seen by the data-memory controller.
interface dmem_ctrl_if;
    // Execute stage side
    logic [1:0]  load2Dmem_command;
    logic [1:0]  load2Dmem_size;
    logic [31:0] load2Dmem_addr;
    logic [31:0] load2Dmem_data;
    logic        load2Dmem_unsigned;
    logic [31:0] Dmem2load_data;
    logic        load_done;
    logic        dmem_busy;

    // Main memory bus side
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [1:0]  proc2mem_size;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    // The controller's view of the bundle
    modport slave (
        input  load2Dmem_command, load2Dmem_size, load2Dmem_addr,
               load2Dmem_data, load2Dmem_unsigned,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output Dmem2load_data, load_done, dmem_busy,
               proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data
    );

    // The environment's view: execute stage plus memory
    modport master (
        output load2Dmem_command, load2Dmem_size, load2Dmem_addr,
               load2Dmem_data, load2Dmem_unsigned,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  Dmem2load_data, load_done, dmem_busy,
               proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: takes one load or store from execute at a time,
// issues it on the tagged memory bus, waits for the matching tag on loads and
// returns the aligned, extended value with a one-cycle completion pulse.
module dmem_ctrl (
    input logic       clock,
    input logic       reset,
    dmem_ctrl_if.slave bus
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  cmd_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        unsigned_q;
    logic [3:0]  tag_q;
    logic [31:0] load_data_q;

    logic        cmd_valid;
    logic        tag_hit;
    logic [31:0] word_sel;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Encoding 3 is not a real command and is treated like BUS_NONE
    assign cmd_valid = (bus.load2Dmem_command == BUS_LOAD) ||
                       (bus.load2Dmem_command == BUS_STORE);

    // A zero tag means "nothing returned", so it can never complete a load
    assign tag_hit = (tag_q != 4'd0) && (bus.mem2proc_tag == tag_q);

    // Pick the addressed byte/half/word out of the returned line and extend it
    always_comb begin
        word_sel = addr_q[2] ? bus.mem2proc_data[63:32] : bus.mem2proc_data[31:0];
        byte_sel = word_sel[{addr_q[1:0], 3'b000} +: 8];
        half_sel = word_sel[{addr_q[1], 4'b0000} +: 16];
        load_ext = word_sel;
        case (size_q)
            SIZE_BYTE: load_ext = unsigned_q ? {24'b0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_ext = unsigned_q ? {16'b0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default:   load_ext = word_sel;
        endcase
    end

    // Transaction FSM: latch the command, issue/re-issue it, wait for the tag
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cmd_q       <= BUS_NONE;
            size_q      <= SIZE_BYTE;
            addr_q      <= 32'b0;
            data_q      <= 32'b0;
            unsigned_q  <= 1'b0;
            tag_q       <= 4'd0;
            load_data_q <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q      <= bus.load2Dmem_command;
                        size_q     <= bus.load2Dmem_size;
                        addr_q     <= bus.load2Dmem_addr;
                        data_q     <= bus.load2Dmem_data;
                        unsigned_q <= bus.load2Dmem_unsigned;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem2proc_response != 4'd0) begin
                        if (cmd_q == BUS_LOAD) begin
                            tag_q <= bus.mem2proc_response;
                            state <= WAIT;
                        end else begin
                            load_data_q <= 32'b0;
                            state       <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (tag_hit) begin
                        load_data_q <= load_ext;
                        tag_q       <= 4'd0;
                        state       <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs depend only on the state and the latched command
    always_comb begin
        bus.proc2mem_command = (state == REQ) ? cmd_q : BUS_NONE;
        bus.proc2mem_addr    = (cmd_q == BUS_LOAD) ? {addr_q[31:3], 3'b000} : addr_q;
        bus.proc2mem_size    = (cmd_q == BUS_LOAD) ? SIZE_DOUBLE : size_q;
        bus.proc2mem_data    = (cmd_q == BUS_STORE) ? {32'b0, data_q} : 64'b0;
    end

    // Execute-side handshake: stall from the first cycle a command is seen
    always_comb begin
        bus.load_done      = (state == DONE);
        bus.dmem_busy      = ((state == IDLE) && cmd_valid) || (state == REQ) ||
                             (state == WAIT);
        bus.Dmem2load_data = load_data_q;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus tasks act as execute stage and
// memory, push expected completions; a monitor pops them on load_done.
module tb_dmem_ctrl;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef struct {
        logic [31:0] data;
        int          done_cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t sb[$];

    dmem_ctrl_if bus_if ();

    dmem_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    // Free-running clock and cycle counter used for latency checks
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (bus_if.load_done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_load_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("load_data", {32'b0, bus_if.Dmem2load_data}, {32'b0, e.data});
                checkOutput("done_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
    end

    // Execute issues a load; memory rejects 'rejects' times, then accepts with
    // 'tag'; 'tag_wait' WAIT cycles of foreign tags precede the real tag.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [63:0] line,
                                 input int rejects, input int tag_wait,
                                 input logic [3:0] tag, input logic [31:0] exp);
        exp_t e;
        @(negedge clock);
        bus_if.load2Dmem_command  = BUS_LOAD;
        bus_if.load2Dmem_addr     = addr;
        bus_if.load2Dmem_size     = size;
        bus_if.load2Dmem_unsigned = uns;
        bus_if.load2Dmem_data     = 32'h5555_5555;
        bus_if.mem2proc_data      = line;
        e.data     = exp;
        e.done_cyc = cyc + 3 + rejects + tag_wait;
        sb.push_back(e);
        #1 checkOutput("busy_on_issue", {63'b0, bus_if.dmem_busy}, 64'd1);
        for (int r = 0; r <= rejects; r++) begin
            @(negedge clock);
            checkOutput("ld_req_cmd", {62'b0, bus_if.proc2mem_command}, {62'b0, BUS_LOAD});
            checkOutput("ld_req_addr", {32'b0, bus_if.proc2mem_addr},
                        {32'b0, addr[31:3], 3'b000});
            checkOutput("ld_req_size", {62'b0, bus_if.proc2mem_size}, {62'b0, SZ_DOUBLE});
            checkOutput("busy_in_req", {63'b0, bus_if.dmem_busy}, 64'd1);
            bus_if.mem2proc_response = (r == rejects) ? tag : 4'd0;
            bus_if.mem2proc_tag      = (r == rejects) ? tag : 4'd2;
        end
        for (int w = 0; w < tag_wait; w++) begin
            @(negedge clock);
            bus_if.mem2proc_response = 4'd0;
            bus_if.mem2proc_tag      = (w % 2 == 1) ? 4'd7 : 4'd2;
            checkOutput("wait_cmd_none", {62'b0, bus_if.proc2mem_command}, {62'b0, BUS_NONE});
            checkOutput("busy_in_wait", {63'b0, bus_if.dmem_busy}, 64'd1);
        end
        @(negedge clock);
        bus_if.mem2proc_response = 4'd0;
        bus_if.mem2proc_tag      = tag;
        checkOutput("busy_at_tag", {63'b0, bus_if.dmem_busy}, 64'd1);
        @(negedge clock);
        bus_if.mem2proc_tag = 4'd0;
        checkOutput("busy_in_done", {63'b0, bus_if.dmem_busy}, 64'd0);
        bus_if.load2Dmem_command = BUS_NONE;
    endtask

    // Execute issues a store; memory rejects 'rejects' times, then accepts
    task automatic applyStore(input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] data, input int rejects);
        exp_t e;
        @(negedge clock);
        bus_if.load2Dmem_command  = BUS_STORE;
        bus_if.load2Dmem_addr     = addr;
        bus_if.load2Dmem_size     = size;
        bus_if.load2Dmem_unsigned = 1'b0;
        bus_if.load2Dmem_data     = data;
        e.data     = 32'h0;
        e.done_cyc = cyc + 2 + rejects;
        sb.push_back(e);
        #1 checkOutput("busy_on_store", {63'b0, bus_if.dmem_busy}, 64'd1);
        for (int r = 0; r <= rejects; r++) begin
            @(negedge clock);
            checkOutput("st_req_cmd", {62'b0, bus_if.proc2mem_command}, {62'b0, BUS_STORE});
            checkOutput("st_req_addr", {32'b0, bus_if.proc2mem_addr}, {32'b0, addr});
            checkOutput("st_req_size", {62'b0, bus_if.proc2mem_size}, {62'b0, size});
            checkOutput("st_req_data", bus_if.proc2mem_data, {32'b0, data});
            bus_if.mem2proc_response = (r == rejects) ? 4'd9 : 4'd0;
        end
        @(negedge clock);
        bus_if.mem2proc_response = 4'd0;
        checkOutput("busy_st_done", {63'b0, bus_if.dmem_busy}, 64'd0);
        bus_if.load2Dmem_command = BUS_NONE;
    endtask

    initial begin
        bus_if.load2Dmem_command  = BUS_NONE;
        bus_if.load2Dmem_size     = SZ_BYTE;
        bus_if.load2Dmem_addr     = 32'h0;
        bus_if.load2Dmem_data     = 32'h0;
        bus_if.load2Dmem_unsigned = 1'b0;
        bus_if.mem2proc_response  = 4'd0;
        bus_if.mem2proc_data      = 64'h0;
        bus_if.mem2proc_tag       = 4'd0;

        repeat (3) @(negedge clock);
        checkOutput("rst_cmd", {62'b0, bus_if.proc2mem_command}, 64'd0);
        checkOutput("rst_addr", {32'b0, bus_if.proc2mem_addr}, 64'd0);
        checkOutput("rst_data", bus_if.proc2mem_data, 64'd0);
        checkOutput("rst_done", {63'b0, bus_if.load_done}, 64'd0);
        checkOutput("rst_busy", {63'b0, bus_if.dmem_busy}, 64'd0);
        checkOutput("rst_ldata", {32'b0, bus_if.Dmem2load_data}, 64'd0);
        reset = 1'b0;

        applyStimulus(32'h104, SZ_WORD, 1'b0, 64'h89ABCDEF_01234567, 0, 3, 4'd3, 32'h89ABCDEF);
        applyStimulus(32'h103, SZ_BYTE, 1'b0, 64'h89ABCDEF_01234567, 0, 0, 4'd1, 32'h00000001);
        applyStimulus(32'h107, SZ_BYTE, 1'b0, 64'h80000000_00000000, 0, 1, 4'd6, 32'hFFFFFF80);
        applyStimulus(32'h107, SZ_BYTE, 1'b1, 64'h80000000_00000000, 0, 0, 4'd1, 32'h00000080);
        applyStimulus(32'h106, SZ_HALF, 1'b0, 64'h89AB0000_00000000, 0, 2, 4'd8, 32'hFFFF89AB);
        applyStimulus(32'h106, SZ_HALF, 1'b1, 64'h89AB0000_00000000, 0, 0, 4'd3, 32'h000089AB);
        applyStimulus(32'h105, SZ_HALF, 1'b1, 64'h89ABCDEF_01234567, 0, 0, 4'd4, 32'h0000CDEF);
        applyStimulus(32'h105, SZ_HALF, 1'b0, 64'h89ABCDEF_01234567, 0, 1, 4'd4, 32'hFFFFCDEF);
        applyStimulus(32'h100, SZ_BYTE, 1'b0, 64'h89ABCDEF_01234567, 0, 0, 4'd1, 32'h00000067);
        applyStimulus(32'h104, SZ_WORD, 1'b0, 64'h89ABCDEF_01234567, 2, 3, 4'd5, 32'h89ABCDEF);

        applyStore(32'h200, SZ_WORD, 32'hDEADBEEF, 0);
        applyStore(32'h301, SZ_BYTE, 32'h000000AB, 1);

        // Reset while a load is waiting on tag 4; the late tag must be dropped
        @(negedge clock);
        bus_if.load2Dmem_command  = BUS_LOAD;
        bus_if.load2Dmem_addr     = 32'h104;
        bus_if.load2Dmem_size     = SZ_WORD;
        bus_if.load2Dmem_unsigned = 1'b0;
        bus_if.mem2proc_data      = 64'h89ABCDEF_01234567;
        @(negedge clock);
        bus_if.mem2proc_response = 4'd4;
        @(negedge clock);
        bus_if.mem2proc_response = 4'd0;
        bus_if.load2Dmem_command = BUS_NONE;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("mid_rst_cmd", {62'b0, bus_if.proc2mem_command}, 64'd0);
        checkOutput("mid_rst_addr", {32'b0, bus_if.proc2mem_addr}, 64'd0);
        checkOutput("mid_rst_data", bus_if.proc2mem_data, 64'd0);
        checkOutput("mid_rst_busy", {63'b0, bus_if.dmem_busy}, 64'd0);
        checkOutput("mid_rst_ldata", {32'b0, bus_if.Dmem2load_data}, 64'd0);
        @(negedge clock);
        bus_if.mem2proc_tag = 4'd4;
        @(negedge clock);
        bus_if.mem2proc_tag = 4'd0;
        checkOutput("late_tag_no_done", {63'b0, bus_if.load_done}, 64'd0);
        @(negedge clock);
        checkOutput("late_tag_no_done2", {63'b0, bus_if.load_done}, 64'd0);

        applyStimulus(32'h104, SZ_WORD, 1'b0, 64'h89ABCDEF_01234567, 0, 1, 4'd3, 32'h89ABCDEF);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
